serial_mag_cmp_ctrl: RTL and testbench

//   Sequences the team's 2-bit magnitude-comparator slice (inputs A/B, outputs EQ/GT) to compare
//   two WIDTH-bit operands, MSB slice first, one slice per clock. Owns the start/busy/done handshake,

---
 rtl/serial_mag_cmp_ctrl_if.sv | 27 ++
 rtl/serial_mag_cmp_ctrl.sv | 133 +++++++++++++
 tb/tb_serial_mag_cmp_ctrl.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/serial_mag_cmp_ctrl_if.sv
// Request/result bus of the serial magnitude comparator controller.
// The requesting datapath uses the master side; the controller uses the slave side.
interface serial_mag_cmp_ctrl_if #(
  parameter int WIDTH = 8,
  parameter int CW    = 3
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             ready;
  logic             busy;
  logic             done;
  logic             eq;
  logic             gt;
  logic             lt;
  logic [CW-1:0]    cycles;

  modport master (
    output start, a, b,
    input  ready, busy, done, eq, gt, lt, cycles
  );

  modport slave (
    input  start, a, b,
    output ready, busy, done, eq, gt, lt, cycles
  );
endinterface

// File: rtl/serial_mag_cmp_ctrl.sv
// Drives one shared combinational 2-bit comparator slice over WIDTH-bit operands, MSB slice first,
// one slice per clock, and registers the first (most significant) difference as the result.
module serial_mag_cmp_ctrl #(
  parameter int WIDTH      = 8,
  parameter int EARLY_EXIT = 1,
  localparam int N         = WIDTH / 2,
  localparam int CW        = $clog2(N + 1),
  localparam int IW        = (N > 1) ? $clog2(N) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  serial_mag_cmp_ctrl_if.slave bus,
  output logic [1:0]          sl_a,
  output logic [1:0]          sl_b,
  input  logic                sl_eq,
  input  logic                sl_gt
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] a_reg, b_reg;
  logic [IW-1:0]    idx, idx_n;
  logic [CW-1:0]    cyc, cyc_n;
  logic             diff, diff_n;
  logic             gt_r, gt_r_n;
  logic             eq_q, gt_q, lt_q;
  logic             eq_n, gt_n, lt_n;
  logic             load;
  logic             first_diff;
  logic             gt_sel;

  function automatic logic [1:0] slice_of(input logic [WIDTH-1:0] v, input logic [IW-1:0] i);
    logic [WIDTH-1:0] sh;
    sh = v >> {i, 1'b0};
    return sh[1:0];
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      a_reg <= '0;
      b_reg <= '0;
      idx   <= '0;
      cyc   <= '0;
      diff  <= 1'b0;
      gt_r  <= 1'b0;
      eq_q  <= 1'b0;
      gt_q  <= 1'b0;
      lt_q  <= 1'b0;
    end else begin
      state <= state_n;
      idx   <= idx_n;
      cyc   <= cyc_n;
      diff  <= diff_n;
      gt_r  <= gt_r_n;
      eq_q  <= eq_n;
      gt_q  <= gt_n;
      lt_q  <= lt_n;
      if (load) begin
        a_reg <= bus.a;
        b_reg <= bus.b;
      end
    end
  end

  // A slice whose EQ is set counts as equal even if GT is also asserted.
  always_comb begin
    state_n    = state;
    idx_n      = idx;
    cyc_n      = cyc;
    diff_n     = diff;
    gt_r_n     = gt_r;
    eq_n       = eq_q;
    gt_n       = gt_q;
    lt_n       = lt_q;
    load       = 1'b0;
    first_diff = 1'b0;
    gt_sel     = gt_r;
    case (state)
      IDLE: begin
        if (bus.start) begin
          load    = 1'b1;
          state_n = RUN;
          idx_n   = IW'(N - 1);
          cyc_n   = '0;
          diff_n  = 1'b0;
          gt_r_n  = 1'b0;
          eq_n    = 1'b0;
          gt_n    = 1'b0;
          lt_n    = 1'b0;
        end
      end
      RUN: begin
        cyc_n      = cyc + 1'b1;
        first_diff = !sl_eq && !diff;
        if (first_diff) begin
          diff_n = 1'b1;
          gt_r_n = sl_gt;
          gt_sel = sl_gt;
        end
        if (((EARLY_EXIT != 0) && first_diff) || (idx == '0)) begin
          state_n = DONE;
          eq_n    = !diff_n;
          gt_n    = diff_n && gt_sel;
          lt_n    = diff_n && !gt_sel;
        end else begin
          idx_n = idx - 1'b1;
        end
      end
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    sl_a = 2'b00;
    sl_b = 2'b00;
    if (state == RUN) begin
      sl_a = slice_of(a_reg, idx);
      sl_b = slice_of(b_reg, idx);
    end
  end

  assign bus.ready  = (state == IDLE);
  assign bus.busy   = (state == RUN);
  assign bus.done   = (state == DONE);
  assign bus.eq     = eq_q;
  assign bus.gt     = gt_q;
  assign bus.lt     = lt_q;
  assign bus.cycles = cyc;

endmodule

// File: tb/tb_serial_mag_cmp_ctrl.sv
// Bench for serial_mag_cmp_ctrl: one early-exit and one constant-time instance share stimulus and
// are checked every cycle against a schedule model derived from operand arithmetic.
module tb_serial_mag_cmp_ctrl;
  localparam int WIDTH = 8;
  localparam int N     = WIDTH / 2;
  localparam int CW    = $clog2(N + 1);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start;
  logic [WIDTH-1:0] a, b;
  logic noise = 1'b0;
  logic [1:0] sla1, slb1, sla0, slb0;
  logic sleq1, slgt1, sleq0, slgt0;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  serial_mag_cmp_ctrl_if #(.WIDTH(WIDTH), .CW(CW)) bus1();
  serial_mag_cmp_ctrl_if #(.WIDTH(WIDTH), .CW(CW)) bus0();

  assign bus1.start = start;
  assign bus1.a     = a;
  assign bus1.b     = b;
  assign bus0.start = start;
  assign bus0.a     = a;
  assign bus0.b     = b;

  // Comparator slices; GT is randomly asserted on equal slices to exercise EQ priority.
  assign sleq1 = (sla1 == slb1);
  assign slgt1 = (sla1 > slb1) | ((sla1 == slb1) & noise);
  assign sleq0 = (sla0 == slb0);
  assign slgt0 = (sla0 > slb0) | ((sla0 == slb0) & noise);

  always @(negedge clk) noise <= 1'($urandom);

  serial_mag_cmp_ctrl #(.WIDTH(WIDTH), .EARLY_EXIT(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(bus1),
    .sl_a(sla1), .sl_b(slb1), .sl_eq(sleq1), .sl_gt(slgt1)
  );

  serial_mag_cmp_ctrl #(.WIDTH(WIDTH), .EARLY_EXIT(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(bus0),
    .sl_a(sla0), .sl_b(slb0), .sl_eq(sleq0), .sl_gt(slgt0)
  );

  // Model: after acceptance, cycle t (1..k) examines slice N-t; cycle k+1 is the done cycle.
  int m_t[2];
  int m_k[2];
  int m_cyc[2];
  logic [WIDTH-1:0] m_a[2];
  logic [WIDTH-1:0] m_b[2];
  logic m_eq[2], m_gt[2], m_lt[2];

  function automatic int calc_k(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y, input int e);
    if (e == 0 || x == y) return N;
    for (int i = N - 1; i >= 0; i--)
      if (((x >> (2 * i)) & 8'h3) != ((y >> (2 * i)) & 8'h3)) return N - i;
    return N;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    for (int e = 0; e < 2; e++) begin
      if (!rst_n) begin
        m_t[e] <= 0; m_k[e] <= N; m_cyc[e] <= 0;
        m_a[e] <= '0; m_b[e] <= '0;
        m_eq[e] <= 1'b0; m_gt[e] <= 1'b0; m_lt[e] <= 1'b0;
      end else if (m_t[e] == 0) begin
        if (start) begin
          m_a[e] <= a; m_b[e] <= b; m_k[e] <= calc_k(a, b, e);
          m_t[e] <= 1; m_cyc[e] <= 0;
          m_eq[e] <= 1'b0; m_gt[e] <= 1'b0; m_lt[e] <= 1'b0;
        end
      end else if (m_t[e] <= m_k[e]) begin
        m_cyc[e] <= m_t[e];
        if (m_t[e] == m_k[e]) begin
          m_t[e]  <= m_k[e] + 1;
          m_eq[e] <= (m_a[e] == m_b[e]);
          m_gt[e] <= (m_a[e] > m_b[e]);
          m_lt[e] <= (m_a[e] < m_b[e]);
        end else begin
          m_t[e] <= m_t[e] + 1;
        end
      end else begin
        m_t[e] <= 0;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_dut(input int e, input logic rdy, input logic bsy, input logic dn,
                           input logic q, input logic g, input logic l,
                           input logic [CW-1:0] cyc, input logic [1:0] sa, input logic [1:0] sb);
    logic run;
    logic [WIDTH-1:0] sh_a, sh_b;
    run  = (m_t[e] >= 1) && (m_t[e] <= m_k[e]);
    sh_a = run ? (m_a[e] >> (2 * (N - m_t[e]))) : '0;
    sh_b = run ? (m_b[e] >> (2 * (N - m_t[e]))) : '0;
    chk($sformatf("dut%0d.ready", e), 32'(rdy), 32'(m_t[e] == 0));
    chk($sformatf("dut%0d.busy", e), 32'(bsy), 32'(run));
    chk($sformatf("dut%0d.done", e), 32'(dn), 32'(m_t[e] == m_k[e] + 1));
    chk($sformatf("dut%0d.eq", e), 32'(q), 32'(m_eq[e]));
    chk($sformatf("dut%0d.gt", e), 32'(g), 32'(m_gt[e]));
    chk($sformatf("dut%0d.lt", e), 32'(l), 32'(m_lt[e]));
    chk($sformatf("dut%0d.cycles", e), 32'(cyc), 32'(m_cyc[e]));
    chk($sformatf("dut%0d.sl_a", e), 32'(sa), 32'(sh_a[1:0]));
    chk($sformatf("dut%0d.sl_b", e), 32'(sb), 32'(sh_b[1:0]));
  endtask

  always @(posedge clk) begin
    #1;
    check_dut(1, bus1.ready, bus1.busy, bus1.done, bus1.eq, bus1.gt, bus1.lt, bus1.cycles, sla1, slb1);
    check_dut(0, bus0.ready, bus0.busy, bus0.done, bus0.eq, bus0.gt, bus0.lt, bus0.cycles, sla0, slb0);
  end

  task automatic run_op(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                        output int lat1, output int lat0, output logic [7:0] seq1);
    int t;
    @(negedge clk);
    start = 1'b1; a = x; b = y;
    @(posedge clk); #1;
    start = 1'b0;
    lat1 = -1; lat0 = -1; seq1 = '0; t = 0;
    if (bus1.busy) seq1 = {seq1[5:0], sla1};
    while ((lat1 < 0 || lat0 < 0) && t < 20) begin
      @(posedge clk); #1;
      t++;
      if (bus1.done && lat1 < 0) lat1 = t;
      if (bus0.done && lat0 < 0) lat0 = t;
      if (bus1.busy) seq1 = {seq1[5:0], sla1};
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int l1, l0, t;
    logic [7:0] s1;
    start = 1'b0; a = '0; b = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset.ready", 32'(bus1.ready), 32'd1);
    chk("reset.cycles", 32'(bus1.cycles), 32'd0);
    @(negedge clk); rst_n = 1'b1;

    run_op(8'hA5, 8'hA5, l1, l0, s1);
    chk("t1.latency", l1, 4);
    chk("t1.slices", 32'(s1), 32'hA5);
    chk("t1.eq", 32'({bus1.eq, bus1.gt, bus1.lt}), 32'b100);
    chk("t1.cycles", 32'(bus1.cycles), 32'd4);

    run_op(8'h80, 8'h7F, l1, l0, s1);
    chk("t2.latency", l1, 1);
    chk("t2.gt", 32'({bus1.eq, bus1.gt, bus1.lt}), 32'b010);
    chk("t2.cycles", 32'(bus1.cycles), 32'd1);
    chk("t2.latency_ct", l0, 4);

    run_op(8'h1C, 8'h1D, l1, l0, s1);
    chk("t3.latency", l1, 4);
    chk("t3.lt", 32'({bus1.eq, bus1.gt, bus1.lt}), 32'b001);
    chk("t3.cycles", 32'(bus1.cycles), 32'd4);

    run_op(8'hC0, 8'h00, l1, l0, s1);
    chk("t4.latency_ct", l0, 4);
    chk("t4.gt_ct", 32'({bus0.eq, bus0.gt, bus0.lt}), 32'b010);
    chk("t4.cycles_ct", 32'(bus0.cycles), 32'd4);
    chk("t4.latency", l1, 1);

    // start pulsed mid-run with different operands
    @(negedge clk); start = 1'b1; a = 8'h30; b = 8'h20;
    @(negedge clk); start = 1'b0;
    @(negedge clk); start = 1'b1; a = 8'h00; b = 8'hFF;
    @(negedge clk); start = 1'b0;
    t = 0;
    while (!bus0.done && t < 20) begin @(posedge clk); #1; t++; end
    chk("t5.done_seen", 32'(bus0.done), 32'd1);
    chk("t5.gt_ct", 32'({bus0.eq, bus0.gt, bus0.lt}), 32'b010);
    chk("t5.gt", 32'({bus1.eq, bus1.gt, bus1.lt}), 32'b010);
    repeat (2) @(posedge clk);

    // start held high with operands changing every cycle
    for (int i = 0; i < 30; i++) begin
      @(negedge clk); start = 1'b1; a = 8'($urandom); b = (i % 3 == 0) ? a : 8'($urandom);
    end
    @(negedge clk); start = 1'b0;
    repeat (8) @(posedge clk);

    // reset two cycles into a run
    @(negedge clk); start = 1'b1; a = 8'h55; b = 8'h55;
    @(negedge clk); start = 1'b0;
    @(negedge clk); rst_n = 1'b0;
    @(posedge clk); #1;
    chk("t6.ready", 32'({bus1.ready, bus1.busy, bus1.done}), 32'b100);
    chk("t6.results", 32'({bus0.eq, bus0.gt, bus0.lt, bus0.cycles}), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    run_op(8'h12, 8'h34, l1, l0, s1);
    chk("t6.after_lat", l1, 2);
    chk("t6.after_lt", 32'({bus1.eq, bus1.gt, bus1.lt}), 32'b001);

    // randomized traffic with occasional resets
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 99) == 0) rst_n = 1'b0;
      else rst_n = 1'b1;
      start = 1'($urandom);
      a = 8'($urandom);
      case ($urandom_range(0, 3))
        0: b = a;
        1: b = a ^ (8'h1 << $urandom_range(0, 7));
        default: b = 8'($urandom);
      endcase
    end
    @(negedge clk); start = 1'b0; rst_n = 1'b1;
    repeat (8) @(posedge clk);
    #2;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
